// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write controller.
package lcd_pkg;

   localparam int unsigned RS_BIT   = 8;
   localparam int unsigned WR_W     = 9;
   localparam int unsigned INIT_LEN = 4;
   localparam int unsigned IDX_W    = $clog2(INIT_LEN);

   typedef enum logic [2:0] {PWRUP, SETUP, EN_HI, WAIT, IDLE} state_e;

   // One LCD write: register select on top of the byte, matching the LSU word layout.
   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_wr_t;

   localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Clear and return-home need the long post-write wait.
   function automatic logic is_long_cmd(input lcd_wr_t w);
      logic [WR_W-1:0] raw;
      raw = w;
      return !raw[RS_BIT] && (w.data == CMD_CLEAR || w.data == CMD_HOME || w.data == CMD_HOME_ALT);
   endfunction

endpackage

// File: rtl/lcd_if.sv
// Write-side handshake between the LSU LCD register and the LCD controller.
interface lcd_if;
   import lcd_pkg::*;

   logic    wr_vld;
   lcd_wr_t wr_data;
   logic    wr_rdy;
   logic    busy;
   logic    init_done;

   modport master (output wr_vld, wr_data, input wr_rdy, busy, init_done);
   modport slave  (input wr_vld, wr_data, output wr_rdy, busy, init_done);

endinterface

// File: rtl/lcd_fifo.sv
// Circular write buffer for the LCD controller; DEPTH must be a power of two >= 2.
module lcd_fifo
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  lcd_wr_t          din,
   output lcd_wr_t          head_c,
   output logic             full_c,
   output logic             empty_c,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   lcd_wr_t          mem [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head_c  = mem[rd_ptr];
   assign full_c  = (count == CNT_W'(DEPTH));
   assign empty_c = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write controller: power-up init, buffered writes, timed EN strobes.
// Define LCD_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned INIT_WAIT_CYCLES  = 750000,
   parameter int unsigned SETUP_CYCLES      = 2,
   parameter int unsigned E_PULSE_CYCLES    = 12,
   parameter int unsigned CMD_WAIT_CYCLES   = 1850,
   parameter int unsigned CLEAR_WAIT_CYCLES = 76000,
   parameter int unsigned FIFO_DEPTH        = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   lcd_if.slave       wr,
   output logic       o_lcd_on,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic       o_lcd_en,
   output logic [7:0] o_lcd_data
);

   localparam int unsigned MAX_CYC = max_u(max_u(INIT_WAIT_CYCLES, CLEAR_WAIT_CYCLES),
                                           max_u(CMD_WAIT_CYCLES, max_u(SETUP_CYCLES, E_PULSE_CYCLES)));
   localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
`ifdef LCD_FIFO_EN
   localparam int unsigned CAP = FIFO_DEPTH;
`else
   localparam int unsigned CAP = 1;
`endif

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   lcd_wr_t          cur, cur_nxt;
   logic             init_done_q, init_done_nxt;
   logic             rdy_q, busy_q;
   logic             push, pop;
   logic             full_c, empty_c;
   lcd_wr_t          head_c;
   logic [OCC_W-1:0] occ, occ_nxt;
   logic             full_nxt;

   assign push = wr.wr_vld && rdy_q && !full_c;

`ifdef LCD_FIFO_EN
   lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .push    (push),
      .pop     (pop),
      .din     (wr.wr_data),
      .head_c  (head_c),
      .full_c  (full_c),
      .empty_c (empty_c),
      .count   (occ)
   );
`else
   lcd_wr_t hold;
   logic    hold_vld;

   // Single-entry buffer; push and pop never coincide because push needs it empty.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold     <= '0;
         hold_vld <= 1'b0;
      end else if (push) begin
         hold     <= wr.wr_data;
         hold_vld <= 1'b1;
      end else if (pop) begin
         hold_vld <= 1'b0;
      end
   end

   assign head_c  = hold;
   assign full_c  = hold_vld;
   assign empty_c = !hold_vld;
   assign occ     = OCC_W'(hold_vld);
`endif

   // Look-ahead occupancy so the registered ready never over-accepts.
   assign occ_nxt  = occ + OCC_W'(push) - OCC_W'(pop);
   assign full_nxt = (occ_nxt == OCC_W'(CAP));

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt + CNT_W'(1);
      idx_nxt       = idx;
      cur_nxt       = cur;
      init_done_nxt = init_done_q;
      pop           = 1'b0;
      case (state)
         PWRUP: if (cnt == CNT_W'(INIT_WAIT_CYCLES - 1)) begin
            state_nxt = SETUP;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            cur_nxt   = {1'b0, INIT_CMDS[0]};
         end
         SETUP: if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            state_nxt = EN_HI;
            cnt_nxt   = '0;
         end
         EN_HI: if (cnt == CNT_W'(E_PULSE_CYCLES - 1)) begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
         end
         WAIT: if (cnt == (is_long_cmd(cur) ? CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1))) begin
            cnt_nxt = '0;
            if (init_done_q) begin
               state_nxt = IDLE;
            end else if (idx == IDX_W'(INIT_LEN - 1)) begin
               init_done_nxt = 1'b1;
               state_nxt     = IDLE;
            end else begin
               idx_nxt   = idx + IDX_W'(1);
               cur_nxt   = {1'b0, INIT_CMDS[idx + IDX_W'(1)]};
               state_nxt = SETUP;
            end
         end
         IDLE: begin
            cnt_nxt = '0;
            if (!empty_c) begin
               pop       = 1'b1;
               cur_nxt   = head_c;
               state_nxt = SETUP;
            end
         end
         default: begin
            state_nxt = PWRUP;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= PWRUP;
         cnt         <= '0;
         idx         <= '0;
         cur         <= '0;
         init_done_q <= 1'b0;
         rdy_q       <= 1'b0;
         busy_q      <= 1'b0;
         o_lcd_on    <= 1'b0;
         o_lcd_en    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         cur         <= cur_nxt;
         init_done_q <= init_done_nxt;
         rdy_q       <= init_done_nxt && !full_nxt;
         busy_q      <= (state_nxt != IDLE) || (occ_nxt != '0);
         o_lcd_on    <= 1'b1;
         o_lcd_en    <= (state_nxt == EN_HI);
      end
   end

   assign wr.wr_rdy    = rdy_q;
   assign wr.busy      = busy_q;
   assign wr.init_done = init_done_q;
   assign o_lcd_rs     = cur.rs;
   assign o_lcd_data   = cur.data;
   assign o_lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing; adapts to LCD_FIFO_EN.
module tb_lcd_ctrl;
   import lcd_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       lcd_on, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   lcd_if wr();

   lcd_ctrl #(
      .INIT_WAIT_CYCLES  (20),
      .SETUP_CYCLES      (1),
      .E_PULSE_CYCLES    (3),
      .CMD_WAIT_CYCLES   (5),
      .CLEAR_WAIT_CYCLES (10),
      .FIFO_DEPTH        (4)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .wr         (wr),
      .o_lcd_on   (lcd_on),
      .o_lcd_rs   (lcd_rs),
      .o_lcd_rw   (lcd_rw),
      .o_lcd_en   (lcd_en),
      .o_lcd_data (lcd_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_chk  = 0;
   int         n_err  = 0;
   int         rw_bad = 0;
   int         rise_q[$];
   int         fall_q[$];
   logic [8:0] word_q[$];
   logic       en_q = 1'b0;

   // Bus monitor: logs each EN pulse with its RS/data and edge numbers.
   always @(negedge clk) begin
      if (lcd_en && !en_q) begin
         rise_q.push_back(cyc);
         word_q.push_back({lcd_rs, lcd_data});
      end
      if (!lcd_en && en_q) fall_q.push_back(cyc);
      if (lcd_en && lcd_rw) rw_bad++;
      en_q = lcd_en;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      rise_q.delete();
      fall_q.delete();
      word_q.delete();
   endtask

   task automatic push_wr(input logic [8:0] w, output int acc);
      int n = 0;
      while (!wr.wr_rdy && n < 500) begin
         tick(1);
         n++;
      end
      check("push_rdy", wr.wr_rdy, 1);
      wr.wr_vld  = 1'b1;
      wr.wr_data = lcd_wr_t'(w);
      @(posedge clk);
      acc = cyc + 1;
      #1;
      wr.wr_vld = 1'b0;
   endtask

   task automatic wait_idle(output int c);
      int n = 0;
      while (wr.busy && n < 2000) begin
         tick(1);
         n++;
      end
      c = cyc;
      check("idle_reached", wr.busy, 0);
   endtask

   task automatic wait_init(output int c);
      int n = 0;
      while (!wr.init_done && n < 300) begin
         tick(1);
         n++;
      end
      c = cyc;
      check("init_done_reached", wr.init_done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         rel, c, a, b;
      int         acc_a[5];
      logic       saw;
      logic [8:0] exp_init[4];
      int         exp_rise[4];
      exp_init = '{9'h038, 9'h00C, 9'h001, 9'h006};
      exp_rise = '{21, 30, 39, 53};

      wr.wr_vld  = 1'b0;
      wr.wr_data = '0;
      tick(3);
      check("rst_lcd_on", lcd_on, 0);
      check("rst_en", lcd_en, 0);
      check("rst_rdy", wr.wr_rdy, 0);
      check("rst_busy", wr.busy, 0);
      check("rst_init_done", wr.init_done, 0);
      check("rst_data", lcd_data, 0);
      check("rst_rs", lcd_rs, 0);

      // Power-up and init sequence, with a refused write pending meanwhile.
      @(negedge clk);
      rst_n = 1'b1;
      rel   = cyc;
      clear_log();
      tick(1);
      check("lcd_on_after_release", lcd_on, 1);
      wr.wr_vld  = 1'b1;
      wr.wr_data = lcd_wr_t'(9'h141);
      saw = 1'b0;
      repeat (30) begin
         tick(1);
         saw |= wr.wr_rdy;
      end
      wr.wr_vld = 1'b0;
      check("rdy_before_init", saw, 0);
      wait_init(c);
      check("init_done_cycle", c - rel, 61);
      check("init_pulses", rise_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("init_word%0d", i), word_q[i], exp_init[i]);
         check($sformatf("init_rise%0d", i), rise_q[i] - rel, exp_rise[i]);
      end
      check("clear_gap", rise_q[3] - fall_q[2], 11);
      check("rdy_after_init", wr.wr_rdy, 1);

      // Single data write 'A'.
      clear_log();
      push_wr(9'h141, a);
      wait_idle(c);
      check("a_busy_len", c - a, 10);
      check("a_latency", rise_q[0] - a, 2);
      check("a_pulse_width", fall_q[0] - rise_q[0], 3);
      check("a_word", word_q[0], 9'h141);
      check("rw_low", rw_bad, 0);

      // Back-to-back writes, delivered in order.
      clear_log();
      for (int i = 0; i < 5; i++) push_wr(9'(9'h150 + i), acc_a[i]);
      check("rdy_full", wr.wr_rdy, 0);
`ifdef LCD_FIFO_EN
      check("b2b_consecutive", acc_a[4] - acc_a[0], 4);
`endif
      wait_idle(c);
      check("b2b_count", word_q.size(), 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("b2b_word%0d", i), word_q[i], 9'(9'h150 + i));

      // Clear followed by data uses the long wait.
      clear_log();
      push_wr(9'h001, a);
      push_wr(9'h142, b);
      wait_idle(c);
      check("clr_word0", word_q[0], 9'h001);
      check("clr_word1", word_q[1], 9'h142);
      check("clr_fall_spacing", fall_q[1] - fall_q[0], 15);

      // Reset during EN high drops EN at once and restarts init with an empty buffer.
      clear_log();
      push_wr(9'h143, a);
      push_wr(9'h144, b);
      c = 0;
      while (!lcd_en && c < 100) begin
         tick(1);
         c++;
      end
      check("en_seen", lcd_en, 1);
      #3 rst_n = 1'b0;
      #2;
      check("rst_mid_en", lcd_en, 0);
      check("rst_mid_rdy", wr.wr_rdy, 0);
      check("rst_mid_busy", wr.busy, 0);
      check("rst_mid_init_done", wr.init_done, 0);
      check("rst_mid_lcd_on", lcd_on, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rel   = cyc;
      clear_log();
      wait_init(c);
      check("reinit_done_cycle", c - rel, 61);
      tick(30);
      check("reinit_pulses", rise_q.size(), 4);
      check("reinit_first_word", word_q[0], 9'h038);
      check("reinit_first_rise", rise_q[0] - rel, 21);
      check("reinit_idle", wr.busy, 0);
      check("reinit_rdy", wr.wr_rdy, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
